// File: rtl/shuffle_cells_iter.sv
// Round-serial 16-cell permutation engine: applies the forward or inverse cell
// shuffle a programmable number of times, one round per clock.
module shuffle_cells_iter #(
   parameter int N  = 64,
   parameter int M  = 4,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic          in_inv,
   input  logic [RW-1:0] in_rounds,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic          busy
);

   localparam int CELLS = N / M;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   localparam logic [3:0] P [16] = '{4'd0, 4'd5, 4'd11, 4'd10, 4'd1, 4'd6, 4'd4, 4'd13,
                                     4'd2, 4'd12, 4'd9, 4'd15, 4'd3, 4'd7, 4'd14, 4'd8};

   fsm_t          fsm_q, fsm_d;
   logic [N-1:0]  state_q, state_d;
   logic [RW-1:0] cnt_q, cnt_d;
   logic          mode_q, mode_d;

   // Forward: cell i takes old cell P[i].
   function automatic logic [N-1:0] round_fwd(input logic [N-1:0] s);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < CELLS; i++) r[M*i +: M] = s[M*int'(P[i]) +: M];
      return r;
   endfunction

   // Inverse: old cell i is scattered to position P[i].
   function automatic logic [N-1:0] round_inv(input logic [N-1:0] s);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < CELLS; i++) r[M*int'(P[i]) +: M] = s[M*i +: M];
      return r;
   endfunction

   // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               state_d = in_data;
               mode_d  = in_inv;
               cnt_d   = in_rounds;
               fsm_d   = (in_rounds == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            state_d = mode_q ? round_inv(state_q) : round_fwd(state_q);
            cnt_d   = cnt_q - RW'(1);
            if (cnt_q == RW'(1)) fsm_d = DONE;
         end
         DONE: begin
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   assign in_ready  = (fsm_q == IDLE);
   assign out_valid = (fsm_q == DONE);
   assign busy      = (fsm_q != IDLE);
   assign out_data  = state_q;

endmodule

// File: tb/tb_shuffle_cells_iter.sv
// Self-checking bench: directed vector table, backpressure and reset-abort
// sequences, and random transactions against a cell-array reference model.
module tb_shuffle_cells_iter;

   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [63:0]   in_data = '0;
   logic          in_inv = 1'b0;
   logic [RW-1:0] in_rounds = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [63:0]   out_data;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   shuffle_cells_iter #(.N(64), .M(4), .RW(RW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_inv(in_inv), .in_rounds(in_rounds),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   localparam int PT [16] = '{0, 5, 11, 10, 1, 6, 4, 13, 2, 12, 9, 15, 3, 7, 14, 8};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Reference: state as an array of cells; the permutation has order 4,
   // so only rounds mod 4 matter.
   function automatic logic [63:0] model(input logic [63:0] d, input logic inv, input int rounds);
      int q [16];
      int cells [16];
      int nxt [16];
      logic [63:0] r;
      for (int i = 0; i < 16; i++) q[PT[i]] = i;
      for (int i = 0; i < 16; i++) cells[i] = int'(d[4*i +: 4]);
      for (int k = 0; k < rounds % 4; k++) begin
         for (int i = 0; i < 16; i++) nxt[i] = inv ? cells[q[i]] : cells[PT[i]];
         cells = nxt;
      end
      r = '0;
      for (int i = 0; i < 16; i++) r[4*i +: 4] = cells[i][3:0];
      return r;
   endfunction

   // One full transaction; noise keeps in_valid high with junk inputs while busy.
   task automatic run_txn(input string name, input logic [63:0] d, input logic inv,
                          input logic [RW-1:0] r, input logic [63:0] exp,
                          input int stall, input bit noise);
      int cyc;
      cyc = 0;
      while (!in_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
      check({name, " ready_before"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_data = d; in_inv = inv; in_rounds = r;
      @(posedge clk); #1;
      in_valid  = noise;
      in_data   = {$urandom, $urandom};
      in_inv    = 1'($urandom);
      in_rounds = RW'($urandom);
      cyc = 0;
      while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
      check({name, " latency"}, 64'(cyc), 64'(r));
      check({name, " flags_done"}, 64'({out_valid, in_ready, busy}), 64'(3'b101));
      check({name, " data"}, out_data, exp);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         check({name, " stall_hold"}, {out_data[62:0], out_valid}, {exp[62:0], 1'b1});
         check({name, " stall_data"}, out_data, exp);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, " after_pop"}, 64'({in_ready, out_valid, busy}), 64'(3'b100));
   endtask

   typedef struct {
      logic [63:0]   data;
      logic          inv;
      logic [RW-1:0] rounds;
      logic [63:0]   exp;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{64'hFEDCBA9876543210, 1'b0, 5'd1,  64'h8E73F9C2D461AB50};
      vecs[1] = '{64'hFEDCBA9876543210, 1'b1, 5'd1,  64'hBE7923AFD516C840};
      vecs[2] = '{64'h0123456789ABCDEF, 1'b0, 5'd4,  64'h0123456789ABCDEF};
      vecs[3] = '{64'h0123456789ABCDEF, 1'b1, 5'd4,  64'h0123456789ABCDEF};
      vecs[4] = '{64'h0123456789ABCDEF, 1'b0, 5'd31, 64'h4186DC502AE937BF};
      vecs[5] = '{64'hDEADBEEFCAFEF00D, 1'b0, 5'd0,  64'hDEADBEEFCAFEF00D};

      #12;
      check("reset_outputs", 64'({out_valid, busy, in_ready}), 64'(3'b001));
      check("reset_data", out_data, 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].inv, vecs[i].rounds,
                 vecs[i].exp, 0, 1'b0);

      // Forward R=3 equals forward R=31 on the same input.
      run_txn("fwd_r3", 64'h0123456789ABCDEF, 1'b0, 5'd3, 64'h4186DC502AE937BF, 0, 1'b0);

      // Backpressure with in_valid held high through RUN and DONE.
      run_txn("backpressure", 64'h13579BDF02468ACE, 1'b1, 5'd3,
              model(64'h13579BDF02468ACE, 1'b1, 3), 10, 1'b1);

      // Reset in the middle of a long run.
      in_valid = 1'b1; in_data = 64'hA5A5A5A55A5A5A5A; in_inv = 1'b0; in_rounds = 5'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("midrun_busy", 64'({busy, out_valid, in_ready}), 64'(3'b100));
      rst = 1'b1;
      #1;
      check("abort_flags", 64'({out_valid, busy, in_ready}), 64'(3'b001));
      check("abort_data", out_data, 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      run_txn("post_abort", 64'hFEDCBA9876543210, 1'b0, 5'd1, 64'h8E73F9C2D461AB50, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         logic [63:0]   d;
         logic          inv;
         logic [RW-1:0] r;
         d   = {$urandom, $urandom};
         inv = 1'($urandom);
         r   = (t % 3 == 0) ? RW'($urandom) : RW'($urandom_range(0, 6));
         run_txn($sformatf("rand%0d", t), d, inv, r, model(d, inv, int'(r)),
                 int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
